// File: rtl/a_if_counter.sv
// Shared-state counter: 32-bit signed value i with a truncated combinational view w,
// plus registered wrap/overflow pulses and a one-shot "alive" pulse after reset release.
module a_if_counter #(
  parameter logic signed [31:0] INIT_VAL = 32'sd10,
  parameter logic signed [31:0] STEP     = 32'sd1,
  parameter int unsigned        W_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr,
  input  logic                load,
  input  logic signed [31:0]  load_val,
  output logic signed [31:0]  i_o,
  output logic [W_WIDTH-1:0]  w_o,
  output logic                w_wrap,
  output logic                ovf,
  output logic                hello
);

  logic signed [31:0] i_q;
  logic signed [31:0] sum;
  logic               armed;
  logic               wrap_next;
  logic               ovf_next;

  always_comb begin
    sum       = i_q + STEP;
    wrap_next = (&i_q[W_WIDTH-1:0]) && ~(|sum[W_WIDTH-1:0]);
    // Signed overflow: operands share a sign, result sign differs.
    ovf_next  = (i_q[31] == STEP[31]) && (sum[31] != i_q[31]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q    <= INIT_VAL;
      w_wrap <= 1'b0;
      ovf    <= 1'b0;
    end else if (clr) begin
      i_q    <= INIT_VAL;
      w_wrap <= 1'b0;
      ovf    <= 1'b0;
    end else if (load) begin
      i_q    <= load_val;
      w_wrap <= 1'b0;
      ovf    <= 1'b0;
    end else if (en) begin
      i_q    <= sum;
      w_wrap <= wrap_next;
      ovf    <= ovf_next;
    end else begin
      w_wrap <= 1'b0;
      ovf    <= 1'b0;
    end
  end

  // hello fires once on the first edge after reset release; armed is re-set only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b1;
      hello <= 1'b0;
    end else begin
      hello <= armed;
      armed <= 1'b0;
    end
  end

  assign i_o = i_q;
  assign w_o = i_q[W_WIDTH-1:0];

endmodule

// File: tb/tb_a_if_counter.sv
// Scoreboard bench for a_if_counter: per-scenario stimulus tables, expected results
// queued on drive and compared after each rising edge.
module tb_a_if_counter;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               clr;
  logic               load;
  logic signed [31:0] load_val;
  logic signed [31:0] i_o;
  logic [7:0]         w_o;
  logic               w_wrap;
  logic               ovf;
  logic               hello;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        en;
    logic        clr;
    logic        load;
    logic [31:0] lv;
    logic [31:0] i;
    logic        wrap;
    logic        ovf;
    logic        hello;
  } stim_t;

  typedef struct {
    string       name;
    logic [31:0] i;
    logic [7:0]  w;
    logic        wrap;
    logic        ovf;
    logic        hello;
  } exp_t;

  exp_t sb[$];

  a_if_counter #(
    .INIT_VAL(32'sd10),
    .STEP    (32'sd1),
    .W_WIDTH (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .i_o     (i_o),
    .w_o     (w_o),
    .w_wrap  (w_wrap),
    .ovf     (ovf),
    .hello   (hello)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic stim_t mk(input logic e, input logic c, input logic l,
                               input logic [31:0] lv, input logic [31:0] ei,
                               input logic ew, input logic eo, input logic eh);
    stim_t s;
    s.en = e; s.clr = c; s.load = l; s.lv = lv;
    s.i = ei; s.wrap = ew; s.ovf = eo; s.hello = eh;
    return s;
  endfunction

  // Drive one request, queue its expected result, advance past the edge.
  task automatic apply(input stim_t s, input string nm);
    exp_t x;
    en = s.en; clr = s.clr; load = s.load; load_val = s.lv;
    x.name = nm; x.i = s.i; x.w = s.i[7:0];
    x.wrap = s.wrap; x.ovf = s.ovf; x.hello = s.hello;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (i_o !== 32'sd10 || w_o !== 8'h0A || w_wrap !== 1'b0 || ovf !== 1'b0 || hello !== 1'b0) begin
      failures++;
      $display("FAIL reset: got i=%h w=%h wrap=%b ovf=%b hello=%b want i=0000000a w=0a wrap=0 ovf=0 hello=0",
               i_o, w_o, w_wrap, ovf, hello);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    stim_t t[5];
    exp_t  x;
    for (int unsigned k = 0; k < 5; k++)
      t[k] = mk(1'b1, 1'b0, 1'b0, '0, 32'd11 + k, 1'b0, 1'b0, (k == 0));
    for (int unsigned k = 0; k < 5; k++) begin
      apply(t[k], $sformatf("count%0d", k));
      x = sb.pop_front();
      checks++;
      if (i_o !== x.i || w_o !== x.w || w_wrap !== x.wrap || ovf !== x.ovf || hello !== x.hello) begin
        failures++;
        $display("FAIL %s: got i=%h w=%h wrap=%b ovf=%b hello=%b want i=%h w=%h wrap=%b ovf=%b hello=%b",
                 x.name, i_o, w_o, w_wrap, ovf, hello, x.i, x.w, x.wrap, x.ovf, x.hello);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t t[5];
    exp_t  x;
    t[0] = mk(1'b0, 1'b0, 1'b1, 32'd253, 32'd253, 1'b0, 1'b0, 1'b0);
    t[1] = mk(1'b1, 1'b0, 1'b0, '0,      32'd254, 1'b0, 1'b0, 1'b0);
    t[2] = mk(1'b1, 1'b0, 1'b0, '0,      32'd255, 1'b0, 1'b0, 1'b0);
    t[3] = mk(1'b1, 1'b0, 1'b0, '0,      32'd256, 1'b1, 1'b0, 1'b0);
    t[4] = mk(1'b1, 1'b0, 1'b0, '0,      32'd257, 1'b0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 5; k++) begin
      apply(t[k], $sformatf("wrap%0d", k));
      x = sb.pop_front();
      checks++;
      if (i_o !== x.i || w_o !== x.w || w_wrap !== x.wrap || ovf !== x.ovf || hello !== x.hello) begin
        failures++;
        $display("FAIL %s: got i=%h w=%h wrap=%b ovf=%b hello=%b want i=%h w=%h wrap=%b ovf=%b hello=%b",
                 x.name, i_o, w_o, w_wrap, ovf, hello, x.i, x.w, x.wrap, x.ovf, x.hello);
      end
    end
  endtask

  task automatic test_overflow();
    stim_t t[4];
    exp_t  x;
    t[0] = mk(1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0);
    t[1] = mk(1'b1, 1'b0, 1'b0, '0,            32'h8000_0000, 1'b1, 1'b1, 1'b0);
    t[2] = mk(1'b0, 1'b0, 1'b0, '0,            32'h8000_0000, 1'b0, 1'b0, 1'b0);
    t[3] = mk(1'b1, 1'b0, 1'b0, '0,            32'h8000_0001, 1'b0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 4; k++) begin
      apply(t[k], $sformatf("ovf%0d", k));
      x = sb.pop_front();
      checks++;
      if (i_o !== x.i || w_o !== x.w || w_wrap !== x.wrap || ovf !== x.ovf || hello !== x.hello) begin
        failures++;
        $display("FAIL %s: got i=%h w=%h wrap=%b ovf=%b hello=%b want i=%h w=%h wrap=%b ovf=%b hello=%b",
                 x.name, i_o, w_o, w_wrap, ovf, hello, x.i, x.w, x.wrap, x.ovf, x.hello);
      end
    end
  endtask

  task automatic test_priority();
    stim_t t[6];
    exp_t  x;
    t[0] = mk(1'b1, 1'b0, 1'b1, 32'd100, 32'd100, 1'b0, 1'b0, 1'b0);
    t[1] = mk(1'b1, 1'b1, 1'b1, 32'd77,  32'd10,  1'b0, 1'b0, 1'b0);
    t[2] = mk(1'b0, 1'b0, 1'b0, 32'd77,  32'd10,  1'b0, 1'b0, 1'b0);
    t[3] = mk(1'b0, 1'b0, 1'b0, 32'd77,  32'd10,  1'b0, 1'b0, 1'b0);
    t[4] = mk(1'b0, 1'b0, 1'b0, 32'd77,  32'd10,  1'b0, 1'b0, 1'b0);
    t[5] = mk(1'b1, 1'b1, 1'b0, 32'd77,  32'd10,  1'b0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 6; k++) begin
      apply(t[k], $sformatf("prio%0d", k));
      x = sb.pop_front();
      checks++;
      if (i_o !== x.i || w_o !== x.w || w_wrap !== x.wrap || ovf !== x.ovf || hello !== x.hello) begin
        failures++;
        $display("FAIL %s: got i=%h w=%h wrap=%b ovf=%b hello=%b want i=%h w=%h wrap=%b ovf=%b hello=%b",
                 x.name, i_o, w_o, w_wrap, ovf, hello, x.i, x.w, x.wrap, x.ovf, x.hello);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t pre[2];
    stim_t post[3];
    exp_t  x;
    pre[0]  = mk(1'b0, 1'b0, 1'b1, 32'd56, 32'd56, 1'b0, 1'b0, 1'b0);
    pre[1]  = mk(1'b1, 1'b0, 1'b0, '0,     32'd57, 1'b0, 1'b0, 1'b0);
    post[0] = mk(1'b0, 1'b0, 1'b0, '0,     32'd10, 1'b0, 1'b0, 1'b1);
    post[1] = mk(1'b1, 1'b0, 1'b0, '0,     32'd11, 1'b0, 1'b0, 1'b0);
    post[2] = mk(1'b1, 1'b0, 1'b0, '0,     32'd12, 1'b0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 2; k++) begin
      apply(pre[k], $sformatf("arst_pre%0d", k));
      x = sb.pop_front();
      checks++;
      if (i_o !== x.i || w_o !== x.w || w_wrap !== x.wrap || ovf !== x.ovf || hello !== x.hello) begin
        failures++;
        $display("FAIL %s: got i=%h w=%h wrap=%b ovf=%b hello=%b want i=%h w=%h wrap=%b ovf=%b hello=%b",
                 x.name, i_o, w_o, w_wrap, ovf, hello, x.i, x.w, x.wrap, x.ovf, x.hello);
      end
    end
    // Mid-cycle reset with a load still requested: must act without a clock edge.
    load = 1'b1; load_val = 32'd99;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (i_o !== 32'sd10 || w_o !== 8'h0A || hello !== 1'b0 || w_wrap !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate: got i=%h w=%h wrap=%b ovf=%b hello=%b want i=0000000a w=0a wrap=0 ovf=0 hello=0",
               i_o, w_o, w_wrap, ovf, hello);
    end
    @(posedge clk);
    #1;
    checks++;
    if (i_o !== 32'sd10 || hello !== 1'b0) begin
      failures++;
      $display("FAIL arst_held: got i=%h hello=%b want i=0000000a hello=0", i_o, hello);
    end
    load = 1'b0;
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      apply(post[k], $sformatf("arst_post%0d", k));
      x = sb.pop_front();
      checks++;
      if (i_o !== x.i || w_o !== x.w || w_wrap !== x.wrap || ovf !== x.ovf || hello !== x.hello) begin
        failures++;
        $display("FAIL %s: got i=%h w=%h wrap=%b ovf=%b hello=%b want i=%h w=%h wrap=%b ovf=%b hello=%b",
                 x.name, i_o, w_o, w_wrap, ovf, hello, x.i, x.w, x.wrap, x.ovf, x.hello);
      end
    end
  endtask

  task automatic test_negative();
    stim_t t[7];
    exp_t  x;
    t[0] = mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0);
    t[1] = mk(1'b1, 1'b0, 1'b0, '0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    t[2] = mk(1'b1, 1'b0, 1'b0, '0, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
    t[3] = mk(1'b1, 1'b0, 1'b0, '0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    t[4] = mk(1'b1, 1'b0, 1'b0, '0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    t[5] = mk(1'b1, 1'b0, 1'b0, '0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    t[6] = mk(1'b1, 1'b0, 1'b0, '0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 7; k++) begin
      apply(t[k], $sformatf("neg%0d", k));
      x = sb.pop_front();
      checks++;
      if (i_o !== x.i || w_o !== x.w || w_wrap !== x.wrap || ovf !== x.ovf || hello !== x.hello) begin
        failures++;
        $display("FAIL %s: got i=%h w=%h wrap=%b ovf=%b hello=%b want i=%h w=%h wrap=%b ovf=%b hello=%b",
                 x.name, i_o, w_o, w_wrap, ovf, hello, x.i, x.w, x.wrap, x.ovf, x.hello);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_overflow();
    test_priority();
    test_async_reset();
    test_negative();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
